// File: rtl/ctrl_decode_stage_if.sv
// ctrl_decode_stage_if: groups the decode stage's bus signals.
//   Upstream (IF/ID side): in_valid, in_instr -> stage; in_ready <- stage;
//                          flush -> stage (redirect squash).
//   Downstream (EX side):  out_valid + control bundle + register fields
//                          <- stage; out_ready -> stage.
//   Status:                bubble_cnt, illegal_cnt <- stage.
// modport slave is the stage's view; modport master is the environment's.
interface ctrl_decode_stage_if #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic [31:0]        in_instr;
    logic               in_ready;
    logic               flush;
    logic               out_ready;
    logic               out_valid;
    logic               regwrite;
    logic               regdst;
    logic               alusrc;
    logic               branch;
    logic               bne;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               extend;
    logic [1:0]         memsize;
    logic               memunsigned;
    logic [ALUOP_W-1:0] aluop;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [15:0]        imm;
    logic               illegal;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   illegal_cnt;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, regwrite, regdst, alusrc, branch, bne,
               memwrite, memtoreg, jump, extend, memsize, memunsigned, aluop,
               rs, rt, rd, imm, illegal, bubble_cnt, illegal_cnt
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, regwrite, regdst, alusrc, branch, bne,
               memwrite, memtoreg, jump, extend, memsize, memunsigned, aluop,
               rs, rt, rd, imm, illegal, bubble_cnt, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered MIPS main-control decode (ID -> ID/EX).
// Decodes op into the control bundle, holds it in an output register with a
// valid/ready handshake, inserts one bubble on a load-use hazard, squashes on
// flush, flags illegal opcodes and counts bubbles / illegal ops (saturating).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    ctrl_decode_stage_if.slave (handshakes, bundle, counters)
module ctrl_decode_stage #(
    parameter int ALUOP_W    = 2,
    parameter bit EN_SUBWORD = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ctrl_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       extend;
        logic [1:0] memsize;
        logic       memunsigned;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    logic [5:0]       op;
    logic [4:0]       f_rs;
    logic [4:0]       f_rt;
    ctrl_t            dec;
    logic             use_rs;
    logic             use_rt;
    logic             hazard;
    logic             in_ready;
    logic             take;

    logic             vld_q;
    ctrl_t            ctrl_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [4:0]       rd_q;
    logic [15:0]      imm_q;
    logic [CNT_W-1:0] bub_q;
    logic [CNT_W-1:0] ill_q;

    assign op   = bus.in_instr[31:26];
    assign f_rs = bus.in_instr[25:21];
    assign f_rt = bus.in_instr[20:16];

    // Load/store size comes from the low opcode bits: xx11 word, xx01 half,
    // xx00 byte. Unsigned loads (LHU/LBU) are the ones with op[2] set.
    always_comb begin
        dec    = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            6'b000000: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                dec.aluop    = 2'b10;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100: begin
                dec.regwrite    = 1'b1;
                dec.alusrc      = 1'b1;
                dec.memtoreg    = 1'b1;
                dec.extend      = 1'b1;
                dec.memsize     = (op[1:0] == 2'b11) ? 2'b00 : (op[0] ? 2'b01 : 2'b10);
                dec.memunsigned = op[2];
                use_rs          = 1'b1;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.extend   = 1'b1;
                dec.memsize  = (op[1:0] == 2'b11) ? 2'b00 : (op[0] ? 2'b01 : 2'b10);
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            6'b000100: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
                dec.extend = 1'b1;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            6'b000101: begin
                dec.bne    = 1'b1;
                dec.aluop  = 2'b01;
                dec.extend = 1'b1;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            6'b001000: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.extend   = 1'b1;
                use_rs       = 1'b1;
            end
            6'b001101: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
                use_rs       = 1'b1;
            end
            6'b000010: begin
                dec.jump = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // Without sub-word support every non-word memory op becomes illegal.
        if (!EN_SUBWORD && (dec.memwrite || dec.memtoreg) && dec.memsize != 2'b00) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs      = 1'b0;
            use_rt      = 1'b0;
        end
    end

    // Load in the output register writing a non-zero rt that the incoming
    // instruction reads: the value is not available to EX in time.
    assign hazard = vld_q && ctrl_q.memtoreg && (rt_q != 5'd0) && bus.in_valid &&
                    ((use_rs && f_rs == rt_q) || (use_rt && f_rt == rt_q));

    assign in_ready = bus.flush | (!hazard && (!vld_q || bus.out_ready));
    assign take     = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            bub_q  <= '0;
            ill_q  <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (hazard) begin
            // Load leaves, input waits one cycle behind a bubble.
            if (bus.out_ready) begin
                vld_q <= 1'b0;
                if (~&bub_q) bub_q <= bub_q + CNT_W'(1);
            end
        end else if (take) begin
            vld_q  <= 1'b1;
            ctrl_q <= dec;
            rs_q   <= f_rs;
            rt_q   <= f_rt;
            rd_q   <= bus.in_instr[15:11];
            imm_q  <= bus.in_instr[15:0];
            if (dec.illegal && ~&ill_q) ill_q <= ill_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_q;
    assign bus.regwrite    = ctrl_q.regwrite;
    assign bus.regdst      = ctrl_q.regdst;
    assign bus.alusrc      = ctrl_q.alusrc;
    assign bus.branch      = ctrl_q.branch;
    assign bus.bne         = ctrl_q.bne;
    assign bus.memwrite    = ctrl_q.memwrite;
    assign bus.memtoreg    = ctrl_q.memtoreg;
    assign bus.jump        = ctrl_q.jump;
    assign bus.extend      = ctrl_q.extend;
    assign bus.memsize     = ctrl_q.memsize;
    assign bus.memunsigned = ctrl_q.memunsigned;
    assign bus.aluop       = ALUOP_W'(ctrl_q.aluop);
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.rs          = rs_q;
    assign bus.rt          = rt_q;
    assign bus.rd          = rd_q;
    assign bus.imm         = imm_q;
    assign bus.bubble_cnt  = bub_q;
    assign bus.illegal_cnt = ill_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: drives two stage instances (sub-word on / 8-bit
// counters, sub-word off / 2-bit counters / 3-bit aluop) with the same input
// stream and compares each against its own reference model.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.ALUOP_W(2), .CNT_W(8)) ia ();
    ctrl_decode_stage_if #(.ALUOP_W(3), .CNT_W(2)) ib ();

    assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
    assign ia.in_instr = in_instr;  assign ib.in_instr = in_instr;
    assign ia.flush = flush;        assign ib.flush = flush;
    assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

    ctrl_decode_stage #(.ALUOP_W(2), .EN_SUBWORD(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    ctrl_decode_stage #(.ALUOP_W(3), .EN_SUBWORD(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    // ---------------- reference model ----------------
    typedef enum int {K_R, K_LD, K_ST, K_BEQ, K_BNE, K_ADDI, K_ORI, K_J, K_ILL} kind_e;

    typedef struct packed {
        logic regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, extend;
        logic [1:0] memsize;
        logic       memunsigned;
        logic [1:0] aluop;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic        v;
        ctl_t        c;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] bc, ic;
    } m_t;

    function automatic logic [1:0] ref_size(input logic [5:0] op);
        case (op)
            6'h21, 6'h25, 6'h29: return 2'd1;
            6'h20, 6'h24, 6'h28: return 2'd2;
            default:             return 2'd0;
        endcase
    endfunction

    function automatic kind_e ref_kind(input logic [5:0] op, input bit sub);
        kind_e k;
        case (op)
            6'h00:                             k = K_R;
            6'h23, 6'h21, 6'h25, 6'h20, 6'h24: k = K_LD;
            6'h2b, 6'h29, 6'h28:               k = K_ST;
            6'h04:                             k = K_BEQ;
            6'h05:                             k = K_BNE;
            6'h08:                             k = K_ADDI;
            6'h0d:                             k = K_ORI;
            6'h02:                             k = K_J;
            default:                           k = K_ILL;
        endcase
        if (!sub && ref_size(op) != 2'd0) k = K_ILL;
        return k;
    endfunction

    function automatic ctl_t ref_dec(input logic [5:0] op, input bit sub);
        ctl_t c;
        c = '0;
        case (ref_kind(op, sub))
            K_R:    begin c.regwrite = 1'b1; c.regdst = 1'b1; c.aluop = 2'd2; end
            K_LD:   begin
                c.regwrite = 1'b1; c.alusrc = 1'b1; c.memtoreg = 1'b1; c.extend = 1'b1;
                c.memsize = ref_size(op);
                c.memunsigned = (op == 6'h25 || op == 6'h24);
            end
            K_ST:   begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.extend = 1'b1; c.memsize = ref_size(op); end
            K_BEQ:  begin c.branch = 1'b1; c.aluop = 2'd1; c.extend = 1'b1; end
            K_BNE:  begin c.bne = 1'b1; c.aluop = 2'd1; c.extend = 1'b1; end
            K_ADDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.extend = 1'b1; end
            K_ORI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = 2'd3; end
            K_J:    c.jump = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic bit m_hz(input m_t m, input bit v, input logic [31:0] ins, input bit sub);
        kind_e k;
        bit rrs, rrt;
        k   = ref_kind(ins[31:26], sub);
        rrs = (k inside {K_R, K_LD, K_ST, K_BEQ, K_BNE, K_ADDI, K_ORI});
        rrt = (k inside {K_R, K_ST, K_BEQ, K_BNE});
        return m.v && m.c.memtoreg && (m.rt != 5'd0) && v &&
               ((rrs && ins[25:21] == m.rt) || (rrt && ins[20:16] == m.rt));
    endfunction

    function automatic bit m_rdy(input m_t m, input bit v, input logic [31:0] ins,
                                 input bit fl, input bit ordy, input bit sub);
        return fl || (!m_hz(m, v, ins, sub) && (!m.v || ordy));
    endfunction

    function automatic m_t m_next(input m_t m, input bit rst, input bit v, input logic [31:0] ins,
                                  input bit fl, input bit ordy, input bit sub, input int cmax);
        m_t n;
        n = m;
        if (rst) return '0;
        if (fl) begin
            n.v = 1'b0;
        end else if (m_hz(m, v, ins, sub)) begin
            if (ordy) begin
                n.v = 1'b0;
                if (n.bc < 32'(cmax)) n.bc = n.bc + 1;
            end
        end else if (v && (!m.v || ordy)) begin
            n.v   = 1'b1;
            n.c   = ref_dec(ins[31:26], sub);
            n.rs  = ins[25:21];
            n.rt  = ins[20:16];
            n.rd  = ins[15:11];
            n.imm = ins[15:0];
            if (n.c.illegal && n.ic < 32'(cmax)) n.ic = n.ic + 1;
        end else if (ordy) begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [63:0] m_pk(input m_t m);
        return {17'b0, m.c.regwrite, m.c.regdst, m.c.alusrc, m.c.branch, m.c.bne, m.c.memwrite,
                m.c.memtoreg, m.c.jump, m.c.extend, m.c.memsize, m.c.memunsigned, 1'b0, m.c.aluop,
                m.c.illegal, m.rs, m.rt, m.rd, m.imm};
    endfunction

    logic [63:0] pk_a, pk_b;
    assign pk_a = {17'b0, ia.regwrite, ia.regdst, ia.alusrc, ia.branch, ia.bne, ia.memwrite,
                   ia.memtoreg, ia.jump, ia.extend, ia.memsize, ia.memunsigned, 1'b0, ia.aluop,
                   ia.illegal, ia.rs, ia.rt, ia.rd, ia.imm};
    assign pk_b = {17'b0, ib.regwrite, ib.regdst, ib.alusrc, ib.branch, ib.bne, ib.memwrite,
                   ib.memtoreg, ib.jump, ib.extend, ib.memsize, ib.memunsigned, ib.aluop,
                   ib.illegal, ib.rs, ib.rt, ib.rd, ib.imm};

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    m_t ma = '0;
    m_t mb = '0;
    bit exp_rdy_a;
    logic dut_rdy_a;

    // One clock: apply inputs at negedge, check in_ready, then registered outputs after the edge.
    task automatic cyc(input bit v, input logic [31:0] ins, input bit fl, input bit ordy, input bit rst);
        bit exp_rdy_b;
        @(negedge clk);
        in_valid = v; in_instr = ins; flush = fl; out_ready = ordy; reset = rst;
        #1;
        exp_rdy_a = m_rdy(ma, v, ins, fl, ordy, 1'b1);
        exp_rdy_b = m_rdy(mb, v, ins, fl, ordy, 1'b0);
        dut_rdy_a = ia.in_ready;
        if (!rst) begin
            chk("a_in_ready", 64'(ia.in_ready), 64'(exp_rdy_a));
            chk("b_in_ready", 64'(ib.in_ready), 64'(exp_rdy_b));
        end
        @(posedge clk);
        ma = m_next(ma, rst, v, ins, fl, ordy, 1'b1, 255);
        mb = m_next(mb, rst, v, ins, fl, ordy, 1'b0, 3);
        #1;
        chk("a_valid", 64'(ia.out_valid), 64'(ma.v));
        chk("b_valid", 64'(ib.out_valid), 64'(mb.v));
        chk("a_cnts", {32'(ia.bubble_cnt), 32'(ia.illegal_cnt)}, {ma.bc, ma.ic});
        chk("b_cnts", {32'(ib.bubble_cnt), 32'(ib.illegal_cnt)}, {mb.bc, mb.ic});
        if (ma.v || rst) chk("a_bundle", pk_a, m_pk(ma));
        if (mb.v || rst) chk("b_bundle", pk_b, m_pk(mb));
    endtask

    localparam logic [31:0] LW9   = 32'h8D090000;  // lw  $9,0($8)
    localparam logic [31:0] ADD9  = 32'h012B5020;  // add $10,$9,$11
    localparam logic [31:0] LW0   = 32'h8D000000;  // lw  $0,0($8)
    localparam logic [31:0] ADD0  = 32'h000B5020;  // add $10,$0,$11
    localparam logic [31:0] ORI   = 32'h350800FF;  // ori $8,$8,0xff
    localparam logic [31:0] LBU   = 32'h912A0004;  // lbu $10,4($9)
    localparam logic [31:0] ILL   = 32'hFC000000;

    logic [5:0] op_pool [0:15] = '{6'h00, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29,
                                   6'h28, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02, 6'h3f, 6'h23};

    function automatic logic [31:0] rnd_instr();
        return {op_pool[$urandom_range(15)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                16'($urandom)};
    endfunction

    initial begin
        logic [31:0] cur;
        bit vv, pend;

        // Reset state
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_pk_a", pk_a, 64'h0);

        // Load-use bubble
        cyc(1'b1, LW9, 1'b0, 1'b1, 1'b0);
        chk("lu_lw", {62'(ia.memtoreg), ia.memsize}, {62'd1, 2'b00});
        cyc(1'b1, ADD9, 1'b0, 1'b1, 1'b0);
        chk("lu_rdy", 64'(dut_rdy_a), 64'd0);
        chk("lu_bubble", 64'(ia.out_valid), 64'd0);
        cyc(1'b1, ADD9, 1'b0, 1'b1, 1'b0);
        chk("lu_add", {61'(ia.out_valid), ia.regdst, ia.aluop}, {61'd1, 1'b1, 2'b10});
        chk("lu_bcnt", 64'(ia.bubble_cnt), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // $0 exemption
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, LW0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, ADD0, 1'b0, 1'b1, 1'b0);
        chk("z_b2b", {32'(ia.out_valid), 32'(ia.bubble_cnt)}, {32'd1, 32'd0});
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure
        cyc(1'b1, ORI, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            cyc(1'b1, ADD9, 1'b0, 1'b0, 1'b0);
            chk("bp_hold", {32'(ia.aluop), 16'(ia.extend), ia.imm}, {32'd3, 16'd0, 16'h00FF});
            chk("bp_rdy", 64'(dut_rdy_a), 64'd0);
        end
        cyc(1'b1, ADD9, 1'b0, 1'b1, 1'b0);
        chk("bp_release", {63'(dut_rdy_a), ia.regdst}, {63'd1, 1'b1});
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Sub-word mode
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, LBU, 1'b0, 1'b1, 1'b0);
        chk("lbu_a", {61'(ia.memsize), ia.memunsigned, ia.illegal}, {61'd2, 1'b1, 1'b0});
        chk("lbu_b", pk_b[46:31], 16'h0001);
        chk("lbu_b_icnt", 64'(ib.illegal_cnt), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Flush during hazard
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, LW9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, ADD9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, ADD9, 1'b1, 1'b0, 1'b0);
        chk("fl_valid", {32'(ia.out_valid), 32'(ia.bubble_cnt)}, {32'd0, 32'd0});
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("fl_discard", 64'(ia.out_valid), 64'd0);

        // Saturation
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b1, ILL, 1'b0, 1'b1, 1'b0);
        chk("sat_b", 64'(ib.illegal_cnt), 64'd3);
        chk("sat_a", 64'(ia.illegal_cnt), 64'd5);

        // Reset mid-backpressure
        cyc(1'b1, LW9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, ADD9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, ADD9, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_a", {pk_a[46:0], 1'(ia.out_valid), 8'(ia.bubble_cnt), 8'(ia.illegal_cnt)}, 64'd0);
        chk("rst_mid_b", {pk_b[46:0], 1'(ib.out_valid), 8'(ib.bubble_cnt), 8'(ib.illegal_cnt)}, 64'd0);

        // Random traffic; an instruction is held until the model says it was taken.
        pend = 1'b0;
        cur  = 32'h0;
        vv   = 1'b0;
        repeat (600) begin
            bit fl, ordy, rst;
            if (!pend) begin
                cur = rnd_instr();
                vv  = ($urandom_range(9) < 7);
            end
            fl   = ($urandom_range(19) == 0);
            ordy = ($urandom_range(9) < 7);
            rst  = ($urandom_range(59) == 0);
            cyc(vv, cur, fl, ordy, rst);
            pend = vv && !exp_rdy_a && !rst;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered, parametrised main-control decode stage for the pipelined MIPS core. It sits between IF/ID and EX. It decodes op/funct into the control bundle, including half/byte load-store and unsigned-load controls. It holds the result in an ID/EX output register with a valid/ready handshake. It detects load-use hazards and inserts one bubble, handles flush, flags illegal opcodes, and keeps saturating bubble and illegal counters.

Parameters:
ALUOP_W, 2, aluop width; must be >= 2. Bits above [1:0] are driven 0.
EN_SUBWORD, 1, 1 = LH/LHU/LB/LBU/SH/SB decoded; 0 = those opcodes are illegal.
CNT_W, 8, width of the saturating bubble_cnt and illegal_cnt.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  IF/ID holds an instruction
in_instr  in  32  instruction word
in_ready  out  1  stage accepts in_instr this cycle
flush  in  1  squash output register and current input (branch/jump redirect)
out_ready  in  1  EX accepts the bundle
out_valid  out  1  bundle valid
regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, extend  out  1 each  control bits (extend: 1 = sign-extend imm, 0 = zero-extend)
memsize  out  2  00 word, 01 half, 10 byte
memunsigned  out  1  zero-extend sub-word load
aluop  out  ALUOP_W  00 add, 01 sub, 10 use funct, 11 or
rs, rt, rd  out  5 each  register fields
imm  out  16  immediate field
illegal  out  1  bundle came from an undecodable opcode
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
illegal_cnt  out  CNT_W  illegal opcodes accepted, saturating

Behaviour:
- Reset: out_valid=0; all control outputs, memsize, aluop, rs/rt/rd/imm, illegal = 0; both counters = 0.
- Decode (op[31:26]). Only the set bits are listed; every other control bit is 0.
  - R-type 000000: regwrite, regdst, aluop=10.
  - LW 100011: regwrite, alusrc, memtoreg, extend, memsize=00.
  - LH 100001 / LHU 100101: as LW, memsize=01; LHU also sets memunsigned.
  - LB 100000 / LBU 100100: as LW, memsize=10; LBU also sets memunsigned.
  - SW 101011 / SH 101001 / SB 101000: alusrc, memwrite, extend, memsize 00/01/10.
  - BEQ 000100: branch, aluop=01, extend.
  - BNE 000101: bne, aluop=01, extend.
  - ADDI 001000: regwrite, alusrc, extend.
  - ORI 001101: regwrite, alusrc, aluop=11.
  - J 000010: jump.
- Illegal opcodes (including sub-word ops when EN_SUBWORD=0): all control bits 0, illegal=1, out_valid=1. The bundle is issued so EX can trap.
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Handshake: a transfer occurs when valid and ready are both high on the same edge. Outputs hold stable while out_valid=1 and out_ready=0.
- Hazard: the output register holds a valid load (memtoreg=1) with rt != 0, and the incoming valid instruction reads that register.
  - rs is read by R-type, load, store, branch and ADDI/ORI.
  - rt is read by R-type, store and branch.
- in_ready = !hazard && (!out_valid || out_ready), or 1 when flush=1.
- Priority per cycle: reset > flush > hazard > normal.
  - flush: next out_valid=0; the current input, if valid, is consumed and discarded; no counter update.
  - hazard with out_ready=1 (or out_valid=0): the load moves on, out_valid becomes 0 (bubble), input is held, bubble_cnt += 1. Next cycle the hazard is clear and the input is accepted. Exactly one bubble per load-use.
  - hazard with out_ready=0: hold everything; no count.
  - normal: load the register when in_ready && in_valid. If the output is consumed with no new input, out_valid=0.
- Counters saturate at 2^CNT_W-1. illegal_cnt increments only when an illegal instruction is accepted (not when flushed).
- A reset asserted mid-stall or mid-hold returns to the reset state on the next edge. No pending bubble survives reset.

Test Plan:
- Load-use bubble: out_ready=1; issue 0x8D090000 (lw $9,0($8)) then 0x012B5020 (add $10,$9,$11). Required: the lw bundle has memtoreg=1, memsize=00; the next cycle has out_valid=0 and in_ready=0; the add appears one cycle later with regdst=1, aluop=10; bubble_cnt=1.
- $0 exemption: issue 0x8D000000 (lw $0) then an add reading $0 (rs=0). Required: no bubble, back-to-back out_valid, bubble_cnt=0.
- Backpressure: ORI 0x350800FF accepted, then out_ready=0 for 3 cycles. Required: outputs stable, aluop=11, extend=0, imm=0x00FF, in_ready=0; releases on the first cycle with out_ready=1.
- Sub-word mode: LBU (op 100100) with EN_SUBWORD=1 gives memsize=10, memunsigned=1. With EN_SUBWORD=0 it gives illegal=1, all controls 0, illegal_cnt=1.
- Flush during hazard: lw $9 is held in the output register, an add using $9 is pending, flush=1. Required: next cycle out_valid=0; the add is discarded; bubble_cnt unchanged.
- Saturation/reset: CNT_W=2, feed 5 illegal ops → illegal_cnt=3. Assert reset mid-backpressure → all outputs and counters 0 after one edge.
